// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Instructions are big-endian: byte lane 0 is the most significant byte.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    localparam int INST_BYTES = 4;
    localparam int BYTE_W     = 8;

    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        return 5'(BYTE_W * (INST_BYTES - 1 - int'(lane)));
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory port and decode handshake bundle of the fetch controller.
// master = fetch controller, slave = memory/decode side.
interface imem_fetch_ctrl_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [BYTE_W-1:0]     mem_wdata;
    logic [BYTE_W-1:0]     mem_rdata;

    logic [31:0]           inst;
    logic [ADDR_W-1:0]     inst_pc;
    logic                  inst_valid;
    logic                  inst_ready;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        output inst,
        output inst_pc,
        output inst_valid,
        input  inst_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output inst_ready
    );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: assembles 32-bit words from a byte-wide memory port
// shared with the program loader, which always wins the port.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data,
    output logic              busy,
    imem_fetch_ctrl_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [1:0]        r_bc;
    logic [1:0]        w_bc_nxt;
    logic [31:0]       r_inst;
    logic [31:0]       w_inst_nxt;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_unused_rpc;

    assign w_unused_rpc = ^redirect_pc[1:0];
    assign w_fetch_addr = r_pc + ADDR_W'(r_bc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_bc    <= 2'd0;
            r_inst  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_bc    <= w_bc_nxt;
            r_inst  <= w_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_bc_nxt    = r_bc;
        w_inst_nxt  = r_inst;
        unique case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = FETCH;
                    w_bc_nxt    = 2'd0;
                end
            end
            FETCH: begin
                // A loader write steals the port, so this cycle's byte is lost.
                if (!ld_valid) begin
                    w_inst_nxt[lane_lsb(r_bc) +: BYTE_W] = bus.mem_rdata;
                    w_bc_nxt = r_bc + 2'd1;
                    if (r_bc == 2'd3) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    w_pc_nxt    = r_pc + ADDR_W'(INST_BYTES);
                    w_bc_nxt    = 2'd0;
                    w_state_nxt = run ? FETCH : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (redirect_valid) begin
            w_pc_nxt    = {redirect_pc[ADDR_W-1:2], 2'b00};
            w_bc_nxt    = 2'd0;
            w_state_nxt = run ? FETCH : IDLE;
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_addr  = (r_state == FETCH) ? w_fetch_addr : r_pc;
        if (ld_valid) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = ld_data;
            bus.mem_addr  = ld_addr;
        end
    end

    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_pc;
    assign bus.inst_valid = (r_state == HOLD);
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide memory model.
// Cycle table rows plus a hand-written reset sequence.
module tb_imem_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       rv;
    logic [7:0] rpc;
    logic       ld;
    logic [7:0] la;
    logic [7:0] ldat;
    logic       busy;
    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W(8),
        .RESET_PC(8'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .redirect_valid(rv),
        .redirect_pc(rpc),
        .ld_valid(ld),
        .ld_addr(la),
        .ld_data(ldat),
        .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            mem[20] <= 8'h00;
            mem[21] <= 8'h00;
            mem[22] <= 8'h00;
            mem[23] <= 8'h06;
            mem[24] <= 8'h11;
            mem[25] <= 8'h22;
            mem[26] <= 8'h33;
            mem[27] <= 8'h44;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        run;
        logic        rv;
        logic [7:0]  rpc;
        logic        ld;
        logic [7:0]  la;
        logic [7:0]  ldat;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [7:0]  ep;
        logic [7:0]  ea;
        logic        ew;
        logic [7:0]  ed;
        logic        eb;
    } vec_t;

    vec_t q[$];

    task automatic add(
        input logic i_run, input logic i_rv, input logic [7:0] i_rpc,
        input logic i_ld, input logic [7:0] i_la, input logic [7:0] i_ldat,
        input logic i_rdy, input logic e_v, input logic [31:0] e_i,
        input logic [7:0] e_p, input logic [7:0] e_a, input logic e_w,
        input logic [7:0] e_d, input logic e_b);
        vec_t v;
        v.run = i_run; v.rv = i_rv; v.rpc = i_rpc;
        v.ld = i_ld; v.la = i_la; v.ldat = i_ldat; v.rdy = i_rdy;
        v.ev = e_v; v.ei = e_i; v.ep = e_p; v.ea = e_a;
        v.ew = e_w; v.ed = e_d; v.eb = e_b;
        q.push_back(v);
    endtask

    task automatic fe(input logic [7:0] a);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, a, 0, 0, 1);
    endtask

    task automatic ho(input logic r, input logic [31:0] w,
                      input logic [7:0] p);
        add(1, 0, 0, 0, 0, 0, r, 1, w, p, p, 0, 0, 1);
    endtask

    task automatic chk(input string n, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 0; rv = 0; rpc = 0; ld = 0; la = 0; ldat = 0;
        bus.inst_ready = 1'b0;

        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0);
        add(1, 1, 8'd20, 0, 0, 0, 1, 0, 0, 0, 8'd0, 0, 0, 0);
        fe(8'd20); fe(8'd21); fe(8'd22); fe(8'd23);
        repeat (7) ho(0, 32'h0000_0006, 8'd20);
        ho(1, 32'h0000_0006, 8'd20);
        fe(8'd24); fe(8'd25);
        add(1, 0, 0, 1, 8'd100, 8'hAB, 1, 0, 0, 0, 8'd100, 1, 8'hAB, 1);
        fe(8'd26); fe(8'd27);
        ho(1, 32'h1122_3344, 8'd24);
        fe(8'd28);
        add(1, 1, 8'h47, 0, 0, 0, 1, 0, 0, 0, 8'd29, 0, 0, 1);
        fe(8'h44); fe(8'h45); fe(8'h46); fe(8'h47);
        add(1, 1, 8'd100, 0, 0, 0, 1, 1, 32'hDFE6_EDF4, 8'h44, 8'h44, 0, 0, 1);
        fe(8'd100); fe(8'd101); fe(8'd102); fe(8'd103);
        ho(1, 32'hABC6_CDD4, 8'd100);
        add(1, 1, 8'd252, 0, 0, 0, 1, 0, 0, 0, 8'd104, 0, 0, 1);
        fe(8'd252); fe(8'd253); fe(8'd254); fe(8'd255);
        ho(1, 32'hE7EE_F5FC, 8'd252);
        fe(8'd0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'd2, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'd3, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 32'h030A_1118, 8'd0, 8'd0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd4, 0, 0, 0);
        add(0, 0, 0, 1, 8'd200, 8'h5A, 0, 0, 0, 0, 8'd200, 1, 8'h5A, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd4, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_inst", -1, bus.inst, 32'd0);

        foreach (q[i]) begin
            run = q[i].run; rv = q[i].rv; rpc = q[i].rpc;
            ld = q[i].ld; la = q[i].la; ldat = q[i].ldat;
            bus.inst_ready = q[i].rdy;
            @(negedge clk);
            chk("valid", i, 32'(bus.inst_valid), 32'(q[i].ev));
            if (q[i].ev) begin
                chk("inst", i, bus.inst, q[i].ei);
                chk("inst_pc", i, 32'(bus.inst_pc), 32'(q[i].ep));
            end
            chk("addr", i, 32'(bus.mem_addr), 32'(q[i].ea));
            chk("we", i, 32'(bus.mem_we), 32'(q[i].ew));
            chk("wdata", i, 32'(bus.mem_wdata), 32'(q[i].ed));
            chk("busy", i, 32'(busy), 32'(q[i].eb));
            @(posedge clk);
            #1;
        end

        run = 1; rv = 0; ld = 0; bus.inst_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hs_valid", 100, 32'(bus.inst_valid), 32'd1);
        chk("hs_inst", 100, bus.inst, 32'h1F26_2D34);
        chk("hs_pc", 100, 32'(bus.inst_pc), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        run = 0;
        @(negedge clk);
        chk("r_valid", 101, 32'(bus.inst_valid), 32'd0);
        chk("r_inst", 101, bus.inst, 32'd0);
        chk("r_pc", 101, 32'(bus.inst_pc), 32'd0);
        chk("r_addr", 101, 32'(bus.mem_addr), 32'd0);
        chk("r_we", 101, 32'(bus.mem_we), 32'd0);
        chk("r_wdata", 101, 32'(bus.mem_wdata), 32'd0);
        chk("r_busy", 101, 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_busy", 102 + k, 32'(busy), 32'd0);
            chk("idle_valid", 102 + k, 32'(bus.inst_valid), 32'd0);
            chk("idle_addr", 102 + k, 32'(bus.mem_addr), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
